verlet_node_fx: RTL

//  Parametrised fixed-point Verlet particle for the rope/cloth simulator; successor to the single-cycle node.

---
 rtl/verlet_node_fx_pkg.sv | 4 +
 rtl/verlet_node_fx_sat_add.sv | 18 +
 rtl/verlet_node_fx.sv | 127 ++++++++++++
 3 files changed

// File: rtl/verlet_node_fx_pkg.sv
// verlet_node_fx_pkg: shared step FSM encoding for the fixed-point Verlet node
package verlet_node_fx_pkg;
   typedef enum logic [1:0] {S_IDLE, S_CALC, S_UPDATE, S_DONE} state_t;
endpackage

// File: rtl/verlet_node_fx_sat_add.sv
// verlet_node_fx_sat_add: signed a+b+c saturated to WIDTH bits with an overflow flag
module verlet_node_fx_sat_add #(
   parameter int WIDTH = 32
) (
   input  logic signed [WIDTH:0]   a,
   input  logic signed [WIDTH:0]   b,
   input  logic signed [WIDTH:0]   c,
   output logic signed [WIDTH-1:0] sum,
   output logic                    ovf
);
   logic signed [WIDTH+2:0] s;
   always_comb begin
      s   = {{2{a[WIDTH]}}, a} + {{2{b[WIDTH]}}, b} + {{2{c[WIDTH]}}, c};
      // in range only when every bit above the WIDTH-bit sign matches it
      ovf = !((&s[WIDTH+2:WIDTH-1]) || !(|s[WIDTH+2:WIDTH-1]));
      sum = ovf ? {s[WIDTH+2], {(WIDTH-1){~s[WIDTH+2]}}} : s[WIDTH-1:0];
   end
endmodule

// File: rtl/verlet_node_fx.sv
// verlet_node_fx: one fixed-point Verlet particle with step handshake, pinning,
// floor clamp, saturation and a ready/valid constraint write-back port
module verlet_node_fx
   import verlet_node_fx_pkg::*;
#(
   parameter int                      WIDTH      = 32,
   parameter int                      FRAC       = 12,
   parameter int                      NODE_ID    = 1,
   parameter int                      BASE_X     = 200,
   parameter int                      DIST       = 10,
   parameter logic signed [WIDTH-1:0] GRAVITY    = 'h333,
   parameter int                      DAMP_SHIFT = 0,
   parameter logic signed [WIDTH-1:0] Y_MAX      = 'h7FFFFFFF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             step_start,
   output logic             step_busy,
   output logic             step_done,
   input  logic             pin_en,
   input  logic             cons_valid,
   output logic             cons_ready,
   input  logic [WIDTH-1:0] cons_x,
   input  logic [WIDTH-1:0] cons_y,
   output logic [WIDTH-1:0] x_pos,
   output logic [WIDTH-1:0] y_pos,
   output logic             sat_err
);
   localparam logic signed [WIDTH-1:0] X0 = WIDTH'(longint'(BASE_X) <<< FRAC);
   localparam logic signed [WIDTH-1:0] Y0 = WIDTH'(longint'(DIST * NODE_ID) <<< FRAC);

   state_t state_q, state_d;
   logic signed [WIDTH-1:0] x_q, x_d, y_q, y_d, px_q, px_d, py_q, py_d, nx, ny;
   logic signed [WIDTH:0] vx_q, vx_d, vy_q, vy_d, dx, dy;
   logic pending_q, pending_d, busy_q, busy_d, done_q, done_d, rdy_q, rdy_d, sat_q, sat_d;
   logic ovx, ovy, hs;

   verlet_node_fx_sat_add #(.WIDTH(WIDTH)) u_add_x (
      .a({x_q[WIDTH-1], x_q}), .b(vx_q), .c('0), .sum(nx), .ovf(ovx));
   verlet_node_fx_sat_add #(.WIDTH(WIDTH)) u_add_y (
      .a({y_q[WIDTH-1], y_q}), .b(vy_q), .c({GRAVITY[WIDTH-1], GRAVITY}), .sum(ny), .ovf(ovy));

   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      px_d      = px_q;
      py_d      = py_q;
      vx_d      = vx_q;
      vy_d      = vy_q;
      pending_d = pending_q;
      sat_d     = sat_q;
      hs        = cons_valid & rdy_q;
      dx        = {x_q[WIDTH-1], x_q} - {px_q[WIDTH-1], px_q};
      dy        = {y_q[WIDTH-1], y_q} - {py_q[WIDTH-1], py_q};
      case (state_q)
         S_IDLE: begin
            if (hs && !pin_en) begin
               x_d = cons_x;
               y_d = cons_y;
            end
            // a step colliding with a constraint write is deferred one cycle, not lost
            if (hs) pending_d = pending_q | step_start;
            else if (step_start || pending_q) begin
               state_d   = S_CALC;
               pending_d = 1'b0;
            end
         end
         S_CALC: begin
            vx_d    = DAMP_SHIFT > 0 ? dx - (dx >>> DAMP_SHIFT) : dx;
            vy_d    = DAMP_SHIFT > 0 ? dy - (dy >>> DAMP_SHIFT) : dy;
            state_d = S_UPDATE;
         end
         S_UPDATE: begin
            sat_d = sat_q | ovx | ovy;
            if (!pin_en) begin
               px_d = x_q;
               x_d  = nx;
               py_d = ny > Y_MAX ? Y_MAX : y_q;
               y_d  = ny > Y_MAX ? Y_MAX : ny;
            end
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = state_d == S_CALC || state_d == S_UPDATE;
      done_d = state_d == S_DONE;
      rdy_d  = state_d == S_IDLE;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         x_q       <= X0;
         px_q      <= X0;
         y_q       <= Y0;
         py_q      <= Y0;
         vx_q      <= '0;
         vy_q      <= '0;
         pending_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         rdy_q     <= 1'b0;
         sat_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         px_q      <= px_d;
         y_q       <= y_d;
         py_q      <= py_d;
         vx_q      <= vx_d;
         vy_q      <= vy_d;
         pending_q <= pending_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         rdy_q     <= rdy_d;
         sat_q     <= sat_d;
      end
   end

   assign step_busy  = busy_q;
   assign step_done  = done_q;
   assign cons_ready = rdy_q;
   assign sat_err    = sat_q;
   assign x_pos      = x_q;
   assign y_pos      = y_q;
endmodule
